// File: rtl/kronos_types.sv
// Shared types for the kronos register write-back tracker.
// Holds the register-index type and the upper bound on tracker depth.
package kronos_types;

  // Largest number of in-flight register writes the tracker supports
  localparam int WBTRACK_DEPTH_MAX = 4;

  // Architectural register index (x0..x31)
  typedef logic [4:0] reg_idx_t;

  // FIFO pointer, wide enough for WBTRACK_DEPTH_MAX slots
  typedef logic [1:0] wbt_ptr_t;

  // Occupancy count, holds 0..WBTRACK_DEPTH_MAX
  typedef logic [2:0] wbt_cnt_t;

  // One-hot decode of a register index into a 32-bit mask
  function automatic logic [31:0] reg_onehot(input reg_idx_t r);
    reg_onehot = 32'd1 << r;
  endfunction

endpackage

// File: rtl/kronos_wbtrack.sv
// kronos_wbtrack: in-order tracker of outstanding register-file writes.
// Issued writes are queued oldest-first; write-back must retire the oldest
// entry, otherwise a one-cycle wb_err pulse is raised.
// Optional feature macro: KRONOS_WBTRACK_BYPASS_EN lets a full tracker accept
// an issue in the same cycle that a write-back frees the head slot.
module kronos_wbtrack
  import kronos_types::*;
#(
  parameter int DEPTH = 2  // legal range 1..WBTRACK_DEPTH_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        issue_vld,
  output logic        issue_rdy,
  input  logic        issue_wr,
  input  reg_idx_t    issue_rd,
  input  logic        wb_en,
  input  reg_idx_t    wb_sel,
  output logic        regwr_pending,
  output reg_idx_t    regwr_sel,
  output logic [31:0] pend_mask,
  output logic [2:0]  pend_cnt,
  output logic        wb_err
);

  if ((DEPTH < 1) || (DEPTH > WBTRACK_DEPTH_MAX)) begin : g_bad_depth
    $error("kronos_wbtrack: DEPTH out of range 1..4");
  end

  localparam wbt_cnt_t DEPTH_C  = wbt_cnt_t'(DEPTH);
  localparam wbt_ptr_t LAST_PTR = wbt_ptr_t'(DEPTH - 1);

  // Storage is sized to the maximum so pointer width matches the index width;
  // slots at or above DEPTH are never written and never become valid.
  reg_idx_t                       entry_r [WBTRACK_DEPTH_MAX];
  logic [WBTRACK_DEPTH_MAX-1:0]   vld_r;
  wbt_ptr_t                       head_r;
  wbt_ptr_t                       tail_r;
  wbt_cnt_t                       count_r;
  logic                           wb_err_r;

  reg_idx_t                       head_s;
  logic                           pop_s;
  logic                           push_s;
  logic                           err_s;
  logic                           rdy_s;
  wbt_cnt_t                       count_nxt_s;
  wbt_ptr_t                       head_nxt_s;
  wbt_ptr_t                       tail_nxt_s;
  logic [WBTRACK_DEPTH_MAX-1:0]   vld_nxt_s;
  logic [31:0]                    mask_s;

  // Advance a pointer, wrapping at the configured depth
  function automatic wbt_ptr_t ptr_next(input wbt_ptr_t p);
    ptr_next = (p == LAST_PTR) ? 2'd0 : (p + 2'd1);
  endfunction

  // Handshake decode: pop, push, protocol error and issue-ready
  always_comb begin
    head_s = entry_r[head_r];
    pop_s  = wb_en & ~flush & (count_r != 3'd0) & (wb_sel == head_s);
    err_s  = wb_en & ~flush & ((count_r == 3'd0) | (wb_sel != head_s));
`ifdef KRONOS_WBTRACK_BYPASS_EN
    rdy_s  = ~flush & ((count_r < DEPTH_C) | ((count_r == DEPTH_C) & pop_s));
`else
    rdy_s  = ~flush & (count_r < DEPTH_C);
`endif
    push_s = issue_vld & rdy_s & issue_wr & (issue_rd != 5'd0);
  end

  // Next-state for pointers, count and slot-valid bits
  always_comb begin
    head_nxt_s = pop_s  ? ptr_next(head_r) : head_r;
    tail_nxt_s = push_s ? ptr_next(tail_r) : tail_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 3'd1;
      2'b01:   count_nxt_s = count_r - 3'd1;
      default: count_nxt_s = count_r;
    endcase
    vld_nxt_s = vld_r;
    // Clear before set: with bypass a full tracker may pop and push the same slot
    if (pop_s) begin
      vld_nxt_s[head_r] = 1'b0;
    end else begin
      vld_nxt_s = vld_nxt_s;
    end
    if (push_s) begin
      vld_nxt_s[tail_r] = 1'b1;
    end else begin
      vld_nxt_s = vld_nxt_s;
    end
  end

  // Pending-register mask: OR of one-hot decodes of every valid slot
  always_comb begin
    mask_s = 32'd0;
    for (int i = 0; i < WBTRACK_DEPTH_MAX; i++) begin
      if (vld_r[i]) begin
        mask_s = mask_s | reg_onehot(entry_r[i]);
      end else begin
        mask_s = mask_s;
      end
    end
    mask_s[0] = 1'b0;
  end

  // Tracker control state: reset and flush empty the queue, else apply push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r   <= 2'd0;
      tail_r   <= 2'd0;
      count_r  <= 3'd0;
      vld_r    <= '0;
      wb_err_r <= 1'b0;
    end else if (flush) begin
      head_r   <= 2'd0;
      tail_r   <= 2'd0;
      count_r  <= 3'd0;
      vld_r    <= '0;
      wb_err_r <= 1'b0;
    end else begin
      head_r   <= head_nxt_s;
      tail_r   <= tail_nxt_s;
      count_r  <= count_nxt_s;
      vld_r    <= vld_nxt_s;
      wb_err_r <= err_s;
    end
  end

  // Entry storage: written on push only, contents are qualified by vld_r
  always_ff @(posedge clk) begin
    if (push_s) begin
      entry_r[tail_r] <= issue_rd;
    end
  end

  assign issue_rdy     = rdy_s;
  assign regwr_pending = (count_r != 3'd0);
  assign regwr_sel     = (count_r != 3'd0) ? head_s : 5'd0;
  assign pend_mask     = mask_s;
  assign pend_cnt      = count_r;
  assign wb_err        = wb_err_r;

endmodule

// File: tb/tb_kronos_wbtrack.sv
// Self-checking bench for kronos_wbtrack (DEPTH=2): directed vector table,
// a wrap-around sequence and random traffic against a queue-based model.
module tb_kronos_wbtrack;
  import kronos_types::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, flush, issue_vld, issue_wr, wb_en;
  logic        issue_rdy, regwr_pending, wb_err;
  reg_idx_t    issue_rd, wb_sel, regwr_sel;
  logic [31:0] pend_mask;
  logic [2:0]  pend_cnt;

  always #5 clk = ~clk;

  kronos_wbtrack #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_vld(issue_vld), .issue_rdy(issue_rdy), .issue_wr(issue_wr), .issue_rd(issue_rd),
    .wb_en(wb_en), .wb_sel(wb_sel),
    .regwr_pending(regwr_pending), .regwr_sel(regwr_sel),
    .pend_mask(pend_mask), .pend_cnt(pend_cnt), .wb_err(wb_err)
  );

  typedef struct {
    bit          rst, flush, vld, wr;
    logic [4:0]  rd;
    bit          wben;
    logic [4:0]  sel;
    bit          tbl;
    bit          exp_rdy;
    logic [2:0]  exp_cnt;
    logic [4:0]  exp_sel;
    logic [31:0] exp_mask;
    bit          exp_err;
  } vec_t;

  int tests  = 0;
  int failed = 0;

  // Reference model: a plain queue of destination registers, oldest first
  int q[$];
  bit m_err = 1'b0;
  bit model_known = 1'b0;

  function automatic vec_t mk(bit r, bit f, bit v, bit w, int rd_i, bit we, int sel_i,
                              bit rdy, int cnt, int so, logic [31:0] m, bit e);
    vec_t x;
    x.rst = r; x.flush = f; x.vld = v; x.wr = w; x.rd = 5'(rd_i);
    x.wben = we; x.sel = 5'(sel_i); x.tbl = 1'b1; x.exp_rdy = rdy;
    x.exp_cnt = 3'(cnt); x.exp_sel = 5'(so); x.exp_mask = m; x.exp_err = e;
    return x;
  endfunction

  function automatic vec_t mkr(bit r, bit f, bit v, bit w, int rd_i, bit we, int sel_i);
    vec_t x;
    x = mk(r, f, v, w, rd_i, we, sel_i, 1'b0, 0, 0, 32'd0, 1'b0);
    x.tbl = 1'b0;
    return x;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m = 32'd0;
    foreach (q[i]) m[q[i]] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // One clock cycle: drive, check issue_rdy, clock, update model, check outputs
  task automatic step(input vec_t v);
    bit mr, mpop, mpush;
    rst = v.rst; flush = v.flush; issue_vld = v.vld; issue_wr = v.wr;
    issue_rd = v.rd; wb_en = v.wben; wb_sel = v.sel;
    #1;
    mpop = v.wben && (q.size() > 0) && (q.size() > 0 ? (v.sel == 5'(q[0])) : 1'b0);
    mr = !v.flush && (q.size() < DEPTH);
`ifdef KRONOS_WBTRACK_BYPASS_EN
    if (!v.flush && q.size() == DEPTH && mpop) mr = 1'b1;
`endif
    if (model_known) begin
      chk("issue_rdy", issue_rdy, mr);
      if (v.tbl) chk("issue_rdy_tbl", issue_rdy, v.exp_rdy);
    end
    @(posedge clk);
    if (v.rst || v.flush) begin
      q.delete();
      m_err = 1'b0;
      if (v.rst) model_known = 1'b1;
    end else begin
      mpush = v.vld && mr && v.wr && (v.rd != 5'd0);
      m_err = v.wben && !mpop;
      if (mpop) void'(q.pop_front());
      if (mpush) q.push_back(int'(v.rd));
    end
    #1;
    if (model_known) begin
      chk("pend_cnt", pend_cnt, q.size());
      chk("regwr_pending", regwr_pending, q.size() != 0);
      chk("regwr_sel", regwr_sel, (q.size() != 0) ? q[0] : 0);
      chk("pend_mask", pend_mask, m_mask());
      chk("wb_err", wb_err, m_err);
      if (v.tbl) begin
        chk("pend_cnt_tbl", pend_cnt, v.exp_cnt);
        chk("regwr_sel_tbl", regwr_sel, v.exp_sel);
        chk("pend_mask_tbl", pend_mask, v.exp_mask);
        chk("wb_err_tbl", wb_err, v.exp_err);
        chk("pending_tbl", regwr_pending, v.exp_cnt != 3'd0);
      end
    end
  endtask

  initial begin
    vec_t tbl[$];
    rst = 1'b1; flush = 1'b0; issue_vld = 1'b0; issue_wr = 1'b0;
    issue_rd = 5'd0; wb_en = 1'b0; wb_sel = 5'd0;
    @(posedge clk); #1;

    //        rst f  v  w  rd  we sel  rdy cnt sel mask         err
    tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0,  1, 0, 0,  32'h0,      0));
    tbl.push_back(mk(0, 0, 1, 1, 5,  0, 0,  1, 1, 5,  32'h20,     0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 5,  1, 0, 0,  32'h0,      0));
    tbl.push_back(mk(0, 0, 1, 1, 3,  0, 0,  1, 1, 3,  32'h8,      0));
    tbl.push_back(mk(0, 0, 1, 1, 7,  0, 0,  1, 2, 3,  32'h88,     0));
    tbl.push_back(mk(0, 0, 1, 1, 9,  0, 0,  0, 2, 3,  32'h88,     0));
`ifdef KRONOS_WBTRACK_BYPASS_EN
    tbl.push_back(mk(0, 0, 1, 1, 9,  1, 3,  1, 2, 7,  32'h280,    0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 2, 7,  32'h280,    0));
`else
    tbl.push_back(mk(0, 0, 1, 1, 9,  1, 3,  0, 1, 7,  32'h80,     0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0,  1, 1, 7,  32'h80,     0));
`endif
    tbl.push_back(mk(0, 1, 0, 0, 0,  0, 0,  0, 0, 0,  32'h0,      0));
    tbl.push_back(mk(0, 0, 1, 1, 4,  0, 0,  1, 1, 4,  32'h10,     0));
    tbl.push_back(mk(0, 0, 1, 1, 4,  0, 0,  1, 2, 4,  32'h10,     0));
`ifdef KRONOS_WBTRACK_BYPASS_EN
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 4,  1, 1, 4,  32'h10,     0));
`else
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 4,  0, 1, 4,  32'h10,     0));
`endif
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 4,  1, 0, 0,  32'h0,      0));
    tbl.push_back(mk(0, 0, 1, 1, 9,  0, 0,  1, 1, 9,  32'h200,    0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 2,  1, 1, 9,  32'h200,    1));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0,  1, 1, 9,  32'h200,    0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 9,  1, 0, 0,  32'h0,      0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 3,  1, 0, 0,  32'h0,      1));
    tbl.push_back(mk(0, 0, 1, 1, 0,  0, 0,  1, 0, 0,  32'h0,      0));
    tbl.push_back(mk(0, 0, 1, 0, 12, 0, 0,  1, 0, 0,  32'h0,      0));
    tbl.push_back(mk(0, 0, 1, 1, 6,  0, 0,  1, 1, 6,  32'h40,     0));
    tbl.push_back(mk(0, 1, 1, 1, 2,  1, 6,  0, 0, 0,  32'h0,      0));
    tbl.push_back(mk(0, 0, 1, 1, 11, 0, 0,  1, 1, 11, 32'h800,    0));
    tbl.push_back(mk(0, 0, 1, 1, 12, 0, 0,  1, 2, 11, 32'h1800,   0));
    tbl.push_back(mk(1, 0, 1, 1, 13, 0, 0,  0, 0, 0,  32'h0,      0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0,  1, 0, 0,  32'h0,      0));

    foreach (tbl[i]) step(tbl[i]);

    // Pointer wrap: overlapped push/pop pairs must retire in issue order
    step(mkr(0, 0, 1, 1, 1, 0, 0));
    for (int k = 0; k < 8; k++) begin
      step(mkr(0, 0, 1, 1, k + 2, 1, k + 1));
      chk("wrap_order", regwr_sel, 32'(k + 2));
      chk("wrap_cnt", pend_cnt, 32'd1);
    end
    step(mkr(0, 0, 0, 0, 0, 1, 9));
    chk("wrap_drained", pend_cnt, 32'd0);

    // Random traffic against the queue model
    for (int n = 0; n < 600; n++) begin
      vec_t v;
      int s;
      s = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[0] : $urandom_range(0, 31);
      v = mkr($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
              $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
              $urandom_range(0, 7), $urandom_range(0, 9) < 4, s);
      step(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
